// File: rtl/spm_pkg.sv
// Shared types for the SpMV datapath: matrix dimension width, channel state and tag layout.
package spm_pkg;

  localparam int unsigned DIM_W = 16;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic             last;
    logic             empty;
  } tag_t;

endpackage

// File: rtl/spm_cisr_chan.sv
// One CISR channel: tracks the remaining length and row of the active row and
// emits a registered tag for every accepted nonzero or granted empty row.
module spm_cisr_chan
  import spm_pkg::*;
#(
  parameter int unsigned LEN_W = 32,
  parameter int unsigned IDX_W = DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             nz_valid,
  input  logic             grant,
  input  logic [IDX_W-1:0] row_id,
  input  logic [LEN_W-1:0] len,
  output logic             free,
  output logic             nz_ready,
  output logic             tag_valid,
  output logic [IDX_W-1:0] tag_row,
  output logic             tag_last,
  output logic             tag_empty
);

  ch_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic             tag_valid_q, tag_valid_d;
  tag_t             tag_q, tag_d;
  logic             active, accept, last_elem;

  assign active    = state_q == CH_ACTIVE;
  assign accept    = nz_valid & active;
  assign last_elem = rem_q == LEN_W'(1);
  // A finishing channel only reloads a nonzero length; an empty head waits until IDLE.
  assign free      = ~active | (accept & last_elem & (len != '0));
  assign nz_ready  = active;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    row_d       = row_q;
    tag_valid_d = 1'b0;
    tag_d       = tag_q;
    if (clear) begin
      state_d = CH_IDLE;
      tag_d   = '0;
    end else begin
      if (accept) begin
        tag_valid_d = 1'b1;
        tag_d.row   = DIM_W'(row_q);
        tag_d.last  = last_elem;
        tag_d.empty = 1'b0;
        if (last_elem) begin
          state_d = CH_IDLE;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      if (grant) begin
        if (len != '0) begin
          state_d = CH_ACTIVE;
          rem_d   = len;
          row_d   = row_id;
        end else begin
          tag_valid_d = 1'b1;
          tag_d.row   = DIM_W'(row_id);
          tag_d.last  = 1'b1;
          tag_d.empty = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CH_IDLE;
      rem_q       <= '0;
      row_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      row_q       <= row_d;
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
    end
  end

  assign tag_valid = tag_valid_q;
  assign tag_row   = IDX_W'(tag_q.row) & {IDX_W{tag_valid_q}};
  assign tag_last  = tag_q.last & tag_valid_q;
  assign tag_empty = tag_q.empty & tag_valid_q;

endmodule

// File: rtl/spm_cisr_row_sched.sv
// CISR row-index scheduler: hands out row IDs to free channels in channel-priority
// order, bounded by num_rows, and reports done / stray-element errors.
module spm_cisr_row_sched
  import spm_pkg::*;
#(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned LEN_W  = 32,
  parameter int unsigned IDX_W  = DIM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [IDX_W-1:0]        num_rows,
  input  logic [NUM_CH*LEN_W-1:0] row_len,
  input  logic [NUM_CH-1:0]       row_len_valid,
  output logic [NUM_CH-1:0]       row_len_ready,
  input  logic [NUM_CH-1:0]       nz_valid,
  output logic [NUM_CH-1:0]       nz_ready,
  output logic [NUM_CH-1:0]       tag_valid,
  output logic [NUM_CH*IDX_W-1:0] tag_row,
  output logic [NUM_CH-1:0]       tag_last,
  output logic [NUM_CH-1:0]       tag_empty,
  output logic                    busy,
  output logic                    done,
  output logic                    err_stray
);

  localparam int unsigned CNT_W = $clog2(NUM_CH) + 1;

  logic [NUM_CH-1:0] free, cand, grant;
  logic [CNT_W-1:0]  rank [NUM_CH];
  logic [CNT_W-1:0]  cand_cnt, grant_cnt;
  logic [IDX_W-1:0]  num_rows_q, assigned_q, remaining;
  logic              busy_q, done_q, err_q, finish;

  assign remaining = num_rows_q - assigned_q;

  always_comb begin
    cand_cnt  = '0;
    grant_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rank[k]   = cand_cnt;
      cand[k]   = free[k] & row_len_valid[k] & busy_q & ~start;
      grant[k]  = cand[k] & (IDX_W'(cand_cnt) < remaining);
      cand_cnt  = cand_cnt + CNT_W'(cand[k]);
      grant_cnt = grant_cnt + CNT_W'(grant[k]);
    end
  end

  assign row_len_ready = grant;

  // next_row always equals the assigned count, so one counter serves both.
  assign finish    = busy_q & (assigned_q == num_rows_q) & ~|nz_ready;
  assign busy      = busy_q & ~finish;
  assign done      = done_q | finish;
  assign err_stray = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_rows_q <= '0;
      assigned_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (start) begin
      num_rows_q <= num_rows;
      assigned_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      assigned_q <= assigned_q + IDX_W'(grant_cnt);
      if (finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (|(nz_valid & ~nz_ready)) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    spm_cisr_chan #(
      .LEN_W(LEN_W),
      .IDX_W(IDX_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start),
      .nz_valid (nz_valid[k]),
      .grant    (grant[k]),
      .row_id   (assigned_q + IDX_W'(rank[k])),
      .len      (row_len[k*LEN_W +: LEN_W]),
      .free     (free[k]),
      .nz_ready (nz_ready[k]),
      .tag_valid(tag_valid[k]),
      .tag_row  (tag_row[k*IDX_W +: IDX_W]),
      .tag_last (tag_last[k]),
      .tag_empty(tag_empty[k])
    );
  end

endmodule

// File: tb/tb_spm_cisr_row_sched.sv
// Directed bench for spm_cisr_row_sched with a per-channel tag scoreboard.
module tb_spm_cisr_row_sched;

  localparam int NC = 4;
  localparam int LW = 8;
  localparam int IW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IW-1:0]    num_rows = '0;
  logic [NC*LW-1:0] row_len = '0;
  logic [NC-1:0]    row_len_valid = '0;
  logic [NC-1:0]    row_len_ready;
  logic [NC-1:0]    nz_valid = '0;
  logic [NC-1:0]    nz_ready;
  logic [NC-1:0]    tag_valid;
  logic [NC*IW-1:0] tag_row;
  logic [NC-1:0]    tag_last;
  logic [NC-1:0]    tag_empty;
  logic             busy, done, err_stray;

  int checks = 0;
  int failures = 0;
  logic [IW+1:0] sbq [NC][$];

  spm_cisr_row_sched #(
    .NUM_CH(NC),
    .LEN_W (LW),
    .IDX_W (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_rows     (num_rows),
    .row_len      (row_len),
    .row_len_valid(row_len_valid),
    .row_len_ready(row_len_ready),
    .nz_valid     (nz_valid),
    .nz_ready     (nz_ready),
    .tag_valid    (tag_valid),
    .tag_row      (tag_row),
    .tag_last     (tag_last),
    .tag_empty    (tag_empty),
    .busy         (busy),
    .done         (done),
    .err_stray    (err_stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int row, input bit last, input bit empty);
    logic [IW-1:0] r;
    r = row[IW-1:0];
    sbq[k].push_back({r, last, empty});
  endtask

  task automatic set_len(input int k, input int v);
    row_len[k*LW +: LW] = v[LW-1:0];
  endtask

  // Advance one clock, then compare every channel's tag against the scoreboard.
  task automatic tick();
    logic [IW+1:0] e;
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      check($sformatf("tag_valid_ch%0d", k), 64'(tag_valid[k]), 64'(sbq[k].size() != 0));
      if (sbq[k].size() != 0) begin
        e = sbq[k].pop_front();
        check($sformatf("tag_ch%0d", k),
              64'({tag_row[k*IW +: IW], tag_last[k], tag_empty[k]}), 64'(e));
      end
    end
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    num_rows = n[IW-1:0];
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    // Reset values
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_tag_valid", 64'(tag_valid), 0);
    check("rst_nz_ready", 64'(nz_ready), 0);
    check("rst_err", 64'(err_stray), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Four channels, lengths {2,1,3,1}, four rows
    do_start(4);
    set_len(0, 2); set_len(1, 1); set_len(2, 3); set_len(3, 1);
    row_len_valid = 4'hF;
    #1 check("a_ready", 64'(row_len_ready), 64'hF);
    tick();
    row_len_valid = 4'h0;
    check("a_nz_ready", 64'(nz_ready), 64'hF);
    nz_valid = 4'hF;
    push(0, 0, 0, 0); push(1, 1, 1, 0); push(2, 2, 0, 0); push(3, 3, 1, 0);
    tick();
    nz_valid = 4'b0101;
    push(0, 0, 1, 0); push(2, 2, 0, 0);
    tick();
    nz_valid = 4'b0100;
    push(2, 2, 1, 0);
    #1 check("a_done_early", 64'(done), 0);
    tick();
    nz_valid = 4'h0;
    check("a_done", 64'(done), 1);
    check("a_busy", 64'(busy), 0);
    check("a_err", 64'(err_stray), 0);
    tick();
    check("a_done_hold", 64'(done), 1);

    // Back-to-back reload on ch0: lengths {2,3}
    do_start(8);
    set_len(0, 2);
    row_len_valid = 4'b0001;
    tick();
    set_len(0, 3);
    nz_valid = 4'b0001;
    push(0, 0, 0, 0);
    #1 check("b_ready_busy", 64'(row_len_ready), 0);
    tick();
    #1 check("b_ready_reload", 64'(row_len_ready), 64'b0001);
    push(0, 0, 1, 0);
    tick();
    row_len_valid = 4'h0;
    push(0, 1, 0, 0); tick();
    push(0, 1, 0, 0); tick();
    push(0, 1, 1, 0); tick();
    nz_valid = 4'h0;
    #1 check("b_busy", 64'(busy), 1);
    check("b_done", 64'(done), 0);

    // Row bound: five rows over four channels
    do_start(5);
    for (int k = 0; k < NC; k++) set_len(k, 1);
    row_len_valid = 4'hF;
    tick();
    nz_valid = 4'hF;
    #1 check("c_ready_limit", 64'(row_len_ready), 64'b0001);
    for (int k = 0; k < NC; k++) push(k, k, 1, 0);
    tick();
    nz_valid = 4'b0001;
    push(0, 4, 1, 0);
    #1 check("c_ready_exhausted", 64'(row_len_ready), 0);
    tick();
    nz_valid = 4'h0;
    #1 check("c_done", 64'(done), 1);
    check("c_ready_after", 64'(row_len_ready), 0);
    row_len_valid = 4'h0;

    // Empty row on ch2
    do_start(3);
    set_len(2, 0);
    row_len_valid = 4'b0100;
    #1 check("d_ready", 64'(row_len_ready), 64'b0100);
    push(2, 0, 1, 1);
    tick();
    row_len_valid = 4'h0;
    check("d_ch2_idle", 64'(nz_ready), 0);
    check("d_busy", 64'(busy), 1);

    // start mid-run drops the pending tag and restarts row IDs
    do_start(4);
    set_len(0, 5);
    row_len_valid = 4'b0001;
    tick();
    row_len_valid = 4'h0;
    nz_valid = 4'b0001;
    push(0, 0, 0, 0);
    tick();
    start = 1'b1;
    num_rows = 4;
    tick();
    start = 1'b0;
    nz_valid = 4'h0;
    check("e_tag_dropped", 64'(tag_valid), 0);
    check("e_nz_ready_clr", 64'(nz_ready), 0);
    set_len(1, 1);
    row_len_valid = 4'b0010;
    tick();
    row_len_valid = 4'h0;
    nz_valid = 4'b0010;
    push(1, 0, 1, 0);
    tick();
    nz_valid = 4'h0;

    // Stray element on idle ch3
    nz_valid = 4'b1000;
    tick();
    nz_valid = 4'h0;
    check("f_err_set", 64'(err_stray), 1);
    tick();
    check("f_err_sticky", 64'(err_stray), 1);
    do_start(1);
    check("f_err_clr", 64'(err_stray), 0);

    // Asynchronous reset mid-cycle
    set_len(0, 4);
    row_len_valid = 4'b0001;
    tick();
    row_len_valid = 4'h0;
    nz_valid = 4'b0001;
    push(0, 0, 0, 0);
    tick();
    nz_valid = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    check("g_tag_valid", 64'(tag_valid), 0);
    check("g_tag_row", 64'(tag_row), 0);
    check("g_busy", 64'(busy), 0);
    check("g_nz_ready", 64'(nz_ready), 0);
    check("g_done", 64'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    left = 0;
    for (int k = 0; k < NC; k++) left += sbq[k].size();
    check("sb_drain", 64'(left), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spm_cisr_row_sched.md
# spm_cisr_row_sched

Parametrised CISR row-index scheduler for the SpMV datapath. It sits between the per-channel row-length buffers and the multiply/accumulate lanes, and tags every nonzero arriving on each channel with its row index. New row IDs are handed out in channel-priority order from a global counter. Beyond the first-generation decoder it adds:
- valid/ready handshakes on row lengths and nonzeros;
- a row-count bound with done detection;
- empty-row (zero-length) events;
- same-cycle row reload;
- stray-element error reporting.

## Interface
Parameters:
- NUM_CH, 16, number of channels (≥1)
- LEN_W, 32, row-length width
- IDX_W, 16, row-index width (matches `DIM_W` in spm_pkg)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear state, latch num_rows, begin run
- num_rows  in  IDX_W  total rows in matrix, sampled on start
- row_len  in  NUM_CH×LEN_W  head of each channel's row-length buffer
- row_len_valid  in  NUM_CH  head entry present
- row_len_ready  out  NUM_CH  pop head entry (combinational)
- nz_valid  in  NUM_CH  nonzero element present on channel
- nz_ready  out  NUM_CH  channel holds an active row (state-only)
- tag_valid  out  NUM_CH  registered tag event
- tag_row  out  NUM_CH×IDX_W  row index of tagged element/empty row
- tag_last  out  NUM_CH  element closes its row (also 1 on empty row)
- tag_empty  out  NUM_CH  event is a zero-length row, no element
- busy  out  1  run in progress
- done  out  1  level: all rows assigned and all channels idle
- err_stray  out  1  sticky: nz_valid seen while nz_ready low

## Operation
- Per-channel state: IDLE or ACTIVE(rem, row). `nz_ready[k] = ACTIVE`.
- Accept: `nz_valid & nz_ready` → next-cycle tag (`row`, `last = (rem==1)`, `empty = 0`).
  - If rem>1: decrement rem.
  - If rem==1: the channel becomes free.
- Free channel k in a cycle: IDLE, or ACTIVE with rem==1 and nz accepted, in which case `row_len[k]` must be ≠0. A zero-length head on a finishing channel waits one cycle until IDLE.
- Candidate: free, row_len_valid, busy, no start this cycle.
- Rank = number of candidates with lower index.
- Granted candidates: `rank < num_rows − assigned`. `row_len_ready` is asserted only on granted candidates.
- Granted channel gets `row = next_row + rank`.
  - row_len≠0 → ACTIVE(rem = row_len).
  - row_len=0 → stays IDLE; next-cycle tag with empty=1, last=1.
- After grants: `next_row` and `assigned` += granted count, using a $clog2(NUM_CH)+1-bit adder zero-extended to IDX_W.
- When `assigned == num_rows`, no further pops occur. Remaining row_len entries are left untouched.
- done = busy & assigned==num_rows & all IDLE. On the cycle done rises, busy falls; done holds until start or reset.
- start (priority over everything):
  - clears channel states, counters, tags and err_stray;
  - latches num_rows and sets busy.
  - num_rows=0 → done asserts the cycle after start.
- Not busy: all ready outputs low. nz_valid is ignored except for err_stray.

## Timing
- Reset (rst_n low, async): all outputs 0, channels IDLE, next_row=0, assigned=0, busy=0, done=0.
- row_len_ready: combinational from row_len_valid, row_len, nz_valid and state, in the same cycle.
- nz_ready: from registered state only; no dependency on nz_valid.
- Tag latency: 1 cycle after accept or empty grant. tag_valid is a single-cycle pulse per event.
- Back-to-back: a channel sustains one element/cycle across row boundaries when the next length is ≠0.
- First element of a newly loaded row is accepted at the earliest the cycle after load.
- start mid-run: the pending tag from the previous cycle is dropped (tag_valid=0 the cycle after start).

## Structure
- spm_pkg holds:
  - `DIM_W`;
  - channel state enum {CH_IDLE, CH_ACTIVE};
  - tag struct {row, last, empty}.
- Sub-module spm_cisr_chan, one instance per channel, contains:
  - the rem/row registers and FSM;
  - the accept logic and the tag register.
  
  It takes grant/row_id/len inputs and drives free/nz_ready.
- Top level contains the rank prefix-count, grant limit, global counters, done/busy and err_stray.

## Test plan
- NUM_CH=4, start num_rows=4, lengths {2,1,3,1} all valid:
  - cycle-1 grants rows 0-3 to ch0-3;
  - ch1/ch3 tags last=1 one cycle after the first accept;
  - done asserts after ch2's third element.
- Ch0 lengths {2,3} with nz_valid held high: tags rows 0,0(last),r,r,r(last) on consecutive cycles with no bubble.
- num_rows=5 with ch0-3 valid: cycle-1 grants rows 0-3; ch0 reload receives row 4; further heads are never popped.
- Ch2 head len=0: row_len_ready[2]=1, next cycle tag_empty=tag_last=1 with correct row; ch2 stays IDLE.
- Boundary and reset cases:
  - start pulsed mid-run → all tags and counters clear, row IDs restart at 0;
  - rst_n low asynchronously mid-cycle → outputs 0 immediately;
  - nz_valid on an IDLE channel → err_stray=1 sticky until start.
